// File: rtl/adder.sv
// AXI4-Lite slave holding two operands and exposing their registered sum and carry-out.
// Every write/read is a single-beat transaction acknowledged one edge after it is accepted.
module adder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    s1_axi_aclk,
   input  logic                    s1_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
   input  logic                    s1_axi_awvalid,
   output logic                    s1_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
   input  logic [DATA_WIDTH/8:0]   s1_axi_wstrb,
   input  logic                    s1_axi_wvalid,
   output logic                    s1_axi_wready,
   output logic                    s1_axi_bresp,
   output logic                    s1_axi_bvalid,
   input  logic                    s1_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
   input  logic                    s1_axi_arvalid,
   output logic                    s1_axi_arready,
   output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
   output logic                    s1_axi_rresp,
   output logic                    s1_axi_rvalid,
   input  logic                    s1_axi_rready
);

   localparam int NLANES = DATA_WIDTH / 8;
   localparam int IDX_W  = ADDR_WIDTH - 2;

   localparam logic [IDX_W-1:0] IDX_OPA   = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_OPB   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_SUM   = IDX_W'(6);
   localparam logic [IDX_W-1:0] IDX_CARRY = IDX_W'(7);

   // Replace only the byte lanes whose strobe is set; the extra top strobe bit has no lane.
   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] cur,
      input logic [DATA_WIDTH-1:0] wd,
      input logic [NLANES:0]       strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = cur;
      for (int i = 0; i < NLANES; i++) begin
         if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

   logic                  rst;
   logic [DATA_WIDTH-1:0] opa_p0;
   logic [DATA_WIDTH-1:0] opb_p0;
   logic [DATA_WIDTH-1:0] sum_p1;
   logic                  carry_p1;

   logic                  wr_accept;
   logic                  rd_accept;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  wr_opa;
   logic                  wr_opb;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  rd_err;
   logic                  unused_bits;

   assign rst         = s1_axi_aresetn;
   assign unused_bits = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0], s1_axi_wstrb[NLANES]};

   assign wr_idx    = s1_axi_awaddr[ADDR_WIDTH-1:2];
   assign rd_idx    = s1_axi_araddr[ADDR_WIDTH-1:2];
   assign wr_opa    = (wr_idx == IDX_OPA);
   assign wr_opb    = (wr_idx == IDX_OPB);
   // awready high during its pulse and a pending response both block a second accept.
   assign wr_accept = s1_axi_awvalid & s1_axi_wvalid & ~s1_axi_awready & ~s1_axi_bvalid;
   assign rd_accept = s1_axi_arvalid & ~s1_axi_arready & ~s1_axi_rvalid;

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      case (rd_idx)
         IDX_OPA:   rd_val = opa_p0;
         IDX_OPB:   rd_val = opb_p0;
         IDX_SUM:   rd_val = sum_p1;
         IDX_CARRY: rd_val = {{(DATA_WIDTH-1){1'b0}}, carry_p1};
         default:   rd_err = 1'b1;
      endcase
   end

   // Stage p0: operand registers and write channel
   always_ff @(posedge s1_axi_aclk) begin
      if (rst) begin
         opa_p0         <= '0;
         opb_p0         <= '0;
         s1_axi_awready <= 1'b0;
         s1_axi_wready  <= 1'b0;
         s1_axi_bvalid  <= 1'b0;
         s1_axi_bresp   <= 1'b0;
      end else begin
         s1_axi_awready <= wr_accept;
         s1_axi_wready  <= wr_accept;
         if (wr_accept) begin
            s1_axi_bvalid <= 1'b1;
            s1_axi_bresp  <= ~(wr_opa | wr_opb);
            if (wr_opa) opa_p0 <= merge_lanes(opa_p0, s1_axi_wdata, s1_axi_wstrb);
            if (wr_opb) opb_p0 <= merge_lanes(opb_p0, s1_axi_wdata, s1_axi_wstrb);
         end else if (s1_axi_bvalid && s1_axi_bready) begin
            s1_axi_bvalid <= 1'b0;
         end
      end
   end

   // Stage p1: registered sum and carry-out
   always_ff @(posedge s1_axi_aclk) begin
      if (rst) begin
         sum_p1   <= '0;
         carry_p1 <= 1'b0;
      end else begin
         {carry_p1, sum_p1} <= {1'b0, opa_p0} + {1'b0, opb_p0};
      end
   end

   // Read channel: data captured on the accept edge and held until taken
   always_ff @(posedge s1_axi_aclk) begin
      if (rst) begin
         s1_axi_arready <= 1'b0;
         s1_axi_rvalid  <= 1'b0;
         s1_axi_rresp   <= 1'b0;
         s1_axi_rdata   <= '0;
      end else begin
         s1_axi_arready <= rd_accept;
         if (rd_accept) begin
            s1_axi_rvalid <= 1'b1;
            s1_axi_rdata  <= rd_val;
            s1_axi_rresp  <= rd_err;
         end else if (s1_axi_rvalid && s1_axi_rready) begin
            s1_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the AXI4-Lite adder: expected responses are queued when a
// transaction is driven and compared when the slave presents its response.
module tb_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [4:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bresp;
   logic        bvalid;
   logic        bready;
   logic [7:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rresp;
   logic        rvalid;
   logic        rready;

   int total = 0;
   int bad   = 0;

   logic        bq[$];
   logic [32:0] rq[$];
   logic [31:0] m_opa = 0;
   logic [31:0] m_opb = 0;

   adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .s1_axi_aclk   (clk),
      .s1_axi_aresetn(rst),
      .s1_axi_awaddr (awaddr),
      .s1_axi_awvalid(awvalid),
      .s1_axi_awready(awready),
      .s1_axi_wdata  (wdata),
      .s1_axi_wstrb  (wstrb),
      .s1_axi_wvalid (wvalid),
      .s1_axi_wready (wready),
      .s1_axi_bresp  (bresp),
      .s1_axi_bvalid (bvalid),
      .s1_axi_bready (bready),
      .s1_axi_araddr (araddr),
      .s1_axi_arvalid(arvalid),
      .s1_axi_arready(arready),
      .s1_axi_rdata  (rdata),
      .s1_axi_rresp  (rresp),
      .s1_axi_rvalid (rvalid),
      .s1_axi_rready (rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [4:0] s);
      logic [31:0] r;
      r = cur;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [32:0] model_rd(input logic [7:0] a);
      logic [32:0] sum33;
      sum33 = {1'b0, m_opa} + {1'b0, m_opb};
      case (a[7:2])
         6'd0:    return {1'b0, m_opa};
         6'd1:    return {1'b0, m_opb};
         6'd6:    return {1'b0, sum33[31:0]};
         6'd7:    return {1'b0, 31'd0, sum33[32]};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   task automatic model_wr(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
      if (a[7:2] == 6'd0) begin
         m_opa = lanes(m_opa, d, s);
         bq.push_back(1'b0);
      end else if (a[7:2] == 6'd1) begin
         m_opb = lanes(m_opb, d, s);
         bq.push_back(1'b0);
      end else begin
         bq.push_back(1'b1);
      end
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      model_wr(a, d, s);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bvalid && n < 20);
      awvalid = 0; wvalid = 0;
      chk("wr_seen", bvalid, 1);
      chk("bresp", bresp, bq.pop_front());
      @(posedge clk); #1;
      chk("bvalid_clr", bvalid, 0);
   endtask

   task automatic do_read(input logic [7:0] a);
      int n;
      logic [32:0] e;
      @(negedge clk);
      araddr = a; arvalid = 1; rready = 1;
      rq.push_back(model_rd(a));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rvalid && n < 20);
      arvalid = 0;
      e = rq.pop_front();
      chk("rd_seen", rvalid, 1);
      chk("rdata", rdata, e[31:0]);
      chk("rresp", rresp, e[32]);
      @(posedge clk); #1;
      chk("rvalid_clr", rvalid, 0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1; awvalid = 0; wvalid = 0; arvalid = 0;
      @(posedge clk); #1;
      chk("rst_ctl", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
      chk("rst_rdata", rdata, 0);
      m_opa = 0; m_opb = 0;
      bq.delete(); rq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      int n;
      logic        eb;
      logic [32:0] er;
      logic [7:0]  addrs [5];
      addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h18; addrs[3] = 8'h1C; addrs[4] = 8'h30;

      rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
      araddr = 0; arvalid = 0; rready = 1;
      reset_dut();
      do_read(8'h00);
      do_read(8'h18);

      // Basic add and carry-out
      do_write(8'h00, 32'd39, 5'hF);
      do_write(8'h04, 32'd40, 5'hF);
      do_read(8'h18);
      do_read(8'h1C);
      do_write(8'h00, 32'd0, 5'hF);
      do_write(8'h03, 32'd39, 5'hF);
      do_read(8'h00);
      do_write(8'h00, 32'hFFFF_FFFF, 5'hF);
      do_write(8'h04, 32'd1, 5'hF);
      do_read(8'h18);
      do_read(8'h1C);

      // Byte strobes, including the ignored top strobe bit
      do_write(8'h00, 32'd0, 5'hF);
      do_write(8'h00, 32'h1234_5678, 5'h1);
      do_read(8'h00);
      do_write(8'h04, 32'hDEAD_BEEF, 5'h0);
      do_write(8'h04, 32'hDEAD_BEEF, 5'h10);
      do_write(8'h04, 32'hCAFE_0000, 5'hC);
      do_read(8'h04);

      // Read-only and unmapped accesses
      do_write(8'h18, 32'd5, 5'hF);
      do_read(8'h18);
      do_write(8'h1C, 32'd5, 5'hF);
      do_write(8'h40, 32'd5, 5'hF);
      do_read(8'h20);
      do_read(8'h1B);

      // Half a write request is never accepted
      @(negedge clk);
      awaddr = 8'h00; wdata = 32'h5555_5555; wstrb = 5'hF; awvalid = 1; wvalid = 0;
      repeat (4) begin @(posedge clk); #1; chk("aw_only", {awready, wready, bvalid}, 0); end
      @(negedge clk);
      awvalid = 0; wvalid = 1;
      repeat (4) begin @(posedge clk); #1; chk("w_only", {awready, wready, bvalid}, 0); end
      @(negedge clk);
      wvalid = 0;
      do_read(8'h00);

      // Simultaneous read and write of OPA returns the old value
      @(negedge clk);
      rq.push_back(model_rd(8'h00));
      awaddr = 8'h00; wdata = 32'h0BAD_F00D; wstrb = 5'hF; awvalid = 1; wvalid = 1;
      araddr = 8'h00; arvalid = 1; bready = 1; rready = 1;
      model_wr(8'h00, 32'h0BAD_F00D, 5'hF);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!(bvalid && rvalid) && n < 20);
      awvalid = 0; wvalid = 0; arvalid = 0;
      er = rq.pop_front();
      chk("sim_wr_seen", bvalid, 1);
      chk("sim_rd_seen", rvalid, 1);
      chk("sim_rdata", rdata, er[31:0]);
      chk("sim_bresp", bresp, bq.pop_front());
      @(posedge clk); #1;
      do_read(8'h00);

      // Stalled responses stay put and block further accepts; reset then aborts them
      @(negedge clk);
      rq.push_back(model_rd(8'h04));
      awaddr = 8'h04; wdata = 32'hA5A5_0001; wstrb = 5'hF; awvalid = 1; wvalid = 1; bready = 0;
      araddr = 8'h04; arvalid = 1; rready = 0;
      model_wr(8'h04, 32'hA5A5_0001, 5'hF);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!(bvalid && rvalid) && n < 20);
      eb = bq.pop_front();
      er = rq.pop_front();
      chk("hold_seen", {bvalid, rvalid}, 2'b11);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("hold_valid", {bvalid, rvalid}, 2'b11);
         chk("hold_ready", {awready, wready, arready}, 0);
         chk("hold_bresp", bresp, eb);
         chk("hold_rdata", {rresp, rdata}, er);
      end
      reset_dut();
      bready = 1; rready = 1;
      do_read(8'h00);
      do_read(8'h04);
      do_read(8'h18);

      // Randomised traffic against the model
      for (int i = 0; i < 24; i++) begin
         logic [7:0] a;
         a = addrs[$urandom_range(0, 4)] | 8'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 5'($urandom_range(0, 31)));
         else do_read(a);
      end
      do_read(8'h18);
      do_read(8'h1C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus / register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 s1_axi_aclk  in  1  clock; all logic on rising edge.
REQ-005 s1_axi_aresetn  in  1  synchronous reset, active-high: asserted when 1, despite the name.
REQ-006 s1_axi_awaddr  in  ADDR_WIDTH  write byte address.
REQ-007 s1_axi_awvalid  in  1 / s1_axi_awready  out  1  write-address handshake.
REQ-008 s1_axi_wdata  in  DATA_WIDTH  write data.
REQ-009 s1_axi_wstrb  in  DATA_WIDTH/8+1  byte-lane enables; bit i enables byte i; top bit (index DATA_WIDTH/8) ignored.
REQ-010 s1_axi_wvalid  in  1 / s1_axi_wready  out  1  write-data handshake.
REQ-011 s1_axi_bresp  out  1  0=OKAY, 1=SLVERR.
REQ-012 s1_axi_bvalid  out  1 / s1_axi_bready  in  1  write-response handshake.
REQ-013 s1_axi_araddr  in  ADDR_WIDTH  read byte address.
REQ-014 s1_axi_arvalid  in  1 / s1_axi_arready  out  1  read-address handshake.
REQ-015 s1_axi_rdata  out  DATA_WIDTH  read data.
REQ-016 s1_axi_rresp  out  1  0=OKAY, 1=SLVERR.
REQ-017 s1_axi_rvalid  out  1 / s1_axi_rready  in  1  read-data handshake.

Function
REQ-018 Register decode SHALL use addr[ADDR_WIDTH-1:2]; addr[1:0] ignored (e.g. 0x03 decodes as 0x00).
REQ-019 Map SHALL be: 0x00 OPA (RW), 0x04 OPB (RW), 0x18 SUM (RO), 0x1C CARRY (RO); all else unmapped.
REQ-020 SUM SHALL equal (OPA+OPB) mod 2^DATA_WIDTH; CARRY SHALL equal {zeros, carry-out of OPA+OPB}.
REQ-021 SUM/CARRY SHALL be registered, updated every cycle from current OPA/OPB; new operand value visible in SUM two edges after write-accept edge at latest.
REQ-022 Write accept SHALL occur when awvalid=1, wvalid=1, awready=0, bvalid=0; next edge pulses awready=wready=1 for exactly one cycle and performs the register write.
REQ-023 awvalid without wvalid (or vice versa) SHALL NOT be accepted; slave waits for both.
REQ-024 Write SHALL update only byte lanes with wstrb[i]=1; wstrb=0 leaves register unchanged but completes with OKAY.
REQ-025 On the accept edge bvalid SHALL go 1; bresp=0 for OPA/OPB, 1 for SUM/CARRY/unmapped (no state change).
REQ-026 bvalid SHALL hold with stable bresp until bready=1 sampled, then clear next edge; no new write accepted while bvalid=1.
REQ-027 Read accept SHALL occur when arvalid=1, arready=0, rvalid=0; next edge pulses arready=1 for one cycle, sets rvalid=1 and latches rdata.
REQ-028 rdata SHALL be register value for mapped addresses (rresp=0); 0 with rresp=1 for unmapped.
REQ-029 rvalid/rdata/rresp SHALL hold stable until rready=1 sampled, then rvalid clears next edge; no new read accepted while rvalid=1.
REQ-030 Read and write channels SHALL be independent; simultaneous read of OPA and write of OPA returns pre-write value.

Reset
REQ-031 While reset=1 at an edge: OPA, OPB, SUM, CARRY = 0; awready, wready, bvalid, bresp, arready, rvalid, rresp = 0; rdata = 0.
REQ-032 Reset mid-transaction SHALL abort it; pending bvalid/rvalid cleared, no partial write retained beyond completed edges.

Verification
REQ-033 Write 0x00=39 (strb 0xF), 0x04=40 -> bresp 0 each; read 0x18 -> 79, 0x1C -> 0.
REQ-034 Write 0x03=39 -> OPA=39; read 0x00 -> 39, rresp 0.
REQ-035 OPA=0xFFFFFFFF, OPB=1 -> read 0x18 -> 0, 0x1C -> 1.
REQ-036 OPA=0, write 0x00=0x12345678 with strb 0x1 -> read 0x00 -> 0x00000078.
REQ-037 Write 0x18=5 -> bresp 1, SUM unchanged; read 0x20 -> rdata 0, rresp 1.
REQ-038 Hold bready=0 / rready=0 for 5 cycles -> bvalid/rvalid and data stay stable, no second accept; assert reset -> all outputs 0 next edge.
